// File: rtl/sram_like_data_responder_if.sv
// SRAM-like data-port bundle between the CPU memory stage and its responder.
// The initiator drives request fields; the responder drives handshake/status.
interface sram_like_data_responder_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wen;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        queue_full;

  modport master (
    output data_req, data_wr, data_size,
    output data_addr, data_wen, data_wdata,
    input  data_addr_ok, data_data_ok,
    input  data_rdata, queue_full
  );

  modport slave (
    input  data_req, data_wr, data_size,
    input  data_addr, data_wen, data_wdata,
    output data_addr_ok, data_data_ok,
    output data_rdata, queue_full
  );
endinterface

// File: rtl/sram_like_data_responder.sv
// SRAM-like data responder: word RAM with fixed-latency in-order replies.
// Define SRAM_RESP_RAND_STALL_EN to add LFSR-driven acceptance stalls.
module sram_like_data_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 2
) (
  input logic clk,
  input logic resetn,
  sram_like_data_responder_if.slave bus
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [PW-1:0] PMAX = PW'(QDEPTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(QDEPTH);
  localparam logic [3:0]    CNT0 = 4'(LATENCY - 1);

  typedef struct packed {
    logic        is_read;
    logic [31:0] rword;
    logic [3:0]  cnt;
  } entry_t;

  entry_t        q [QDEPTH];
  logic [31:0]   mem [2**ADDR_W];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   rdata_q;
  logic [ADDR_W-1:0] idx;
  logic pop;
  logic push;
  logic room;
  logic go;
  logic unused_bits;

  assign unused_bits = ^{bus.data_size,
                         bus.data_addr[31:ADDR_W+2],
                         bus.data_addr[1:0]};

`ifdef SRAM_RESP_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5],
               lfsr[15:1]};
    end
  end

  assign go = lfsr[0];
`else
  assign go = 1'b1;
`endif

  assign idx  = bus.data_addr[ADDR_W+1:2];
  // Head pops the cycle its countdown has expired.
  assign pop  = (count != '0) && (q[head].cnt == 4'd0);
  assign room = (count != CMAX) || pop;
  assign push = bus.data_addr_ok;

  assign bus.data_addr_ok = bus.data_req && room && go;
  assign bus.data_data_ok = pop;
  assign bus.queue_full   = (count == CMAX);
  assign bus.data_rdata   =
    (pop && q[head].is_read) ? q[head].rword : rdata_q;

  always_ff @(posedge clk) begin
    if (resetn && push && bus.data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_wen[b]) begin
          mem[idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      rdata_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (q[i].cnt != 4'd0) begin
          q[i].cnt <= q[i].cnt - 4'd1;
        end
      end
      // Tail slot is free, or is the head popping this edge.
      if (push) begin
        q[tail].is_read <= !bus.data_wr;
        q[tail].rword   <= mem[idx];
        q[tail].cnt     <= CNT0;
        tail <= (tail == PMAX) ? '0 : tail + 1'b1;
      end
      if (pop) begin
        head <= (head == PMAX) ? '0 : head + 1'b1;
        if (q[head].is_read) begin
          rdata_q <= q[head].rword;
        end
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_like_data_responder.sv
// Bench for sram_like_data_responder: directed table plus random traffic.
// Three instances with different LATENCY/QDEPTH share one stimulus stream.
module tb_sram_like_data_responder;
  localparam int NI = 3;

  function automatic int lat_of(int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int qd_of(int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = '0;
  logic [3:0]  wen = '0;
  logic [31:0] wdata = '0;

  logic        aok  [NI];
  logic        ok   [NI];
  logic        full [NI];
  logic [31:0] rd   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_like_data_responder_if bus ();
    assign bus.data_req   = req;
    assign bus.data_wr    = wr;
    assign bus.data_size  = size;
    assign bus.data_addr  = addr;
    assign bus.data_wen   = wen;
    assign bus.data_wdata = wdata;
    assign aok[g]  = bus.data_addr_ok;
    assign ok[g]   = bus.data_data_ok;
    assign full[g] = bus.queue_full;
    assign rd[g]   = bus.data_rdata;
    sram_like_data_responder #(
      .ADDR_W  (12),
      .LATENCY (lat_of(g)),
      .QDEPTH  (qd_of(g))
    ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
    );
  end

  // Reference: each response is due at a cycle number; one per cycle.
  typedef struct {
    int          due;
    logic        is_read;
    bit          known;
    logic [31:0] word;
  } rsp_t;

  rsp_t        mq   [NI][$];
  logic [31:0] mm   [NI][4096];
  bit          mk   [NI][4096];
  logic [31:0] mrd  [NI];
  bit          mrdk [NI];
  int          last_due [NI];
  logic [15:0] mlfsr [NI];
  int          cyc;
  int          n_chk;
  int          n_pass;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mq[k].delete();
      mrd[k]      = '0;
      mrdk[k]     = 1'b1;
      last_due[k] = -1;
      mlfsr[k]    = 16'hACE1;
    end
  endtask

  // Check current-cycle outputs, then advance the model across the edge.
  task automatic cycle();
    #1;
    for (int k = 0; k < NI; k++) begin
      bit   pop;
      bit   xa;
      int   n;
      int   idx;
      rsp_t e;
      n   = mq[k].size();
      pop = (n > 0) && (mq[k][0].due == cyc);
      xa  = req && (n < qd_of(k) || pop);
`ifdef SRAM_RESP_RAND_STALL_EN
      xa  = xa && mlfsr[k][0];
`endif
      check($sformatf("addr_ok[%0d]", k), 32'(aok[k]), 32'(xa));
      check($sformatf("data_ok[%0d]", k), 32'(ok[k]), 32'(pop));
      check($sformatf("full[%0d]", k), 32'(full[k]),
            32'(n == qd_of(k)));
      if (pop && mq[k][0].is_read) begin
        if (mq[k][0].known) begin
          check($sformatf("rdata[%0d]", k), rd[k], mq[k][0].word);
        end
      end else if (mrdk[k]) begin
        check($sformatf("rdata_hold[%0d]", k), rd[k], mrd[k]);
      end
      if (!resetn) begin
        mq[k].delete();
        mrd[k]      = '0;
        mrdk[k]     = 1'b1;
        last_due[k] = -1;
        mlfsr[k]    = 16'hACE1;
      end else begin
        if (pop) begin
          e = mq[k].pop_front();
          if (e.is_read) begin
            mrd[k]  = e.word;
            mrdk[k] = e.known;
          end
        end
        if (xa) begin
          idx     = int'(addr[13:2]);
          e.due   = cyc + lat_of(k);
          if (last_due[k] + 1 > e.due) e.due = last_due[k] + 1;
          last_due[k] = e.due;
          e.is_read = !wr;
          e.word    = mm[k][idx];
          e.known   = mk[k][idx];
          mq[k].push_back(e);
          if (wr) begin
            for (int b = 0; b < 4; b++) begin
              if (wen[b]) mm[k][idx][8*b +: 8] = wdata[8*b +: 8];
            end
            if (wen == 4'hF) mk[k][idx] = 1'b1;
          end
        end
        mlfsr[k] = {mlfsr[k][0] ^ mlfsr[k][2] ^
                    mlfsr[k][3] ^ mlfsr[k][5],
                    mlfsr[k][15:1]};
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  typedef struct {
    bit          rstn;
    bit          req;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    bit          e_aok;
    bit          e_ok;
    bit          e_full;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tv [$];

  function automatic vec_t v(bit rs, bit rq, bit w,
                             logic [31:0] a, logic [3:0] be,
                             logic [31:0] d, bit xa, bit xo,
                             bit xf, logic [31:0] xr);
    vec_t t;
    t.rstn = rs;  t.req = rq;  t.wr = w;
    t.addr = a;   t.wen = be;  t.wdata = d;
    t.e_aok = xa; t.e_ok = xo; t.e_full = xf;
    t.e_rd = xr;
    return t;
  endfunction

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] MX = 32'h1122AB44;
  localparam logic [31:0] CF = 32'hCAFEF00D;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    cyc    = 0;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 4096; i++) mk[k][i] = 1'b0;
    end

    // Expected values below are for instance 0 (LATENCY 2, QDEPTH 2).
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,0,0,32'h0));
    tv.push_back(v(1,1,1,32'h10,4'hF,DB,          1,0,0,32'h0));
    tv.push_back(v(1,1,1,32'h20,4'hF,32'h11223344,1,0,0,32'h0));
    tv.push_back(v(1,1,1,32'h21,4'h2,32'h0000AB00,1,1,1,32'h0));
    tv.push_back(v(1,1,0,32'h10,4'h0,32'h0,       1,1,1,32'h0));
    tv.push_back(v(1,1,0,32'h20,4'h0,32'h0,       1,1,1,32'h0));
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,1,1,DB));
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,1,0,MX));
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,0,0,MX));
    tv.push_back(v(1,1,0,32'h10,4'h0,32'h0,       1,0,0,MX));
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,0,0,MX));
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,1,0,DB));
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,0,0,DB));
    tv.push_back(v(1,1,0,32'h10,4'h0,32'h0,       1,0,0,DB));
    tv.push_back(v(1,1,0,32'h20,4'h0,32'h0,       1,0,0,DB));
    tv.push_back(v(1,1,0,32'h10,4'h0,32'h0,       1,1,1,DB));
    tv.push_back(v(1,1,0,32'h20,4'h0,32'h0,       1,1,1,MX));
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,1,1,DB));
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,1,0,MX));
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,0,0,MX));
    tv.push_back(v(1,1,1,32'h40,4'hF,CF,          1,0,0,MX));
    tv.push_back(v(1,1,0,32'h10,4'h0,32'h0,       1,0,0,MX));
    tv.push_back(v(0,0,0,32'h00,4'h0,32'h0,       0,1,1,MX));
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,0,0,32'h0));
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,0,0,32'h0));
    tv.push_back(v(1,1,0,32'h80004040,4'h0,32'h0, 1,0,0,32'h0));
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,0,0,32'h0));
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,1,0,CF));
    tv.push_back(v(1,0,0,32'h00,4'h0,32'h0,       0,0,0,CF));

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();

    for (int r = 0; r < tv.size(); r++) begin
      resetn = tv[r].rstn;
      req    = tv[r].req;
      wr     = tv[r].wr;
      addr   = tv[r].addr;
      wen    = tv[r].wen;
      wdata  = tv[r].wdata;
      size   = 2'b10;
`ifndef SRAM_RESP_RAND_STALL_EN
      #1;
      check($sformatf("tv%0d.addr_ok", r), 32'(aok[0]),
            32'(tv[r].e_aok));
      check($sformatf("tv%0d.data_ok", r), 32'(ok[0]),
            32'(tv[r].e_ok));
      check($sformatf("tv%0d.full", r), 32'(full[0]),
            32'(tv[r].e_full));
      check($sformatf("tv%0d.rdata", r), rd[0], tv[r].e_rd);
`endif
      cycle();
    end

    resetn = 1'b1;
    for (int i = 0; i < 900; i++) begin
      logic [31:0] a;
      resetn = ($urandom_range(0, 249) != 0);
      req    = ($urandom_range(0, 3) != 0);
      wr     = $urandom_range(0, 1) == 1;
      a      = $urandom;
      a[13:2] = {6'b0, 6'($urandom)};
      addr   = a;
      wen    = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      wdata  = $urandom;
      size   = 2'($urandom);
      cycle();
    end

    resetn = 1'b1;
    req    = 1'b0;
    repeat (30) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
